bb_capture_bank: RTL

- Parametrised multi-channel harness for unresolved black-box instances in netlist benchmarks.
- Generalises the fixed two-instance, hard-wired tie-off pattern in three ways:
  - drives per-channel constant tie-offs (A, B, C bus) from parameters;
  - samples each channel's OUT/COUT response every enabled cycle and counts changes per channel;
  - streams per-channel records out through a valid/ready readout FSM.
- Sits beside N black-box instances inside benchmark top-levels so the netlist has real sequential logic around them.

---
 rtl/bb_capture_pkg.sv | 19 +
 rtl/bb_capture_chan.sv | 44 ++++
 rtl/bb_capture_bank.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bb_capture_pkg.sv
// Shared types and helpers for the black-box capture bank.
package bb_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 4;

    // Saturating counter maximum for the default counter width.
    localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bb_capture_chan.sv
// One black-box channel: last-sample register, first-sample guard and
// saturating change counter with a clear that still honours a same-cycle change.
module bb_capture_chan
    import bb_capture_pkg::*;
#(
    parameter int OUT_W = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [OUT_W:0]   din,
    input  logic             clr,
    output logic [OUT_W:0]   sample,
    output logic [CNT_W-1:0] count,
    output logic             mismatch
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic prev_valid;

    assign mismatch = en & prev_valid & (din != sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample     <= '0;
            prev_valid <= 1'b0;
            count      <= '0;
        end else begin
            if (en) begin
                sample     <= din;
                prev_valid <= 1'b1;
            end
            // A cleared channel that changes in the same cycle restarts at one.
            if (clr) begin
                count <= mismatch ? CNT_W'(1) : '0;
            end else if (mismatch && count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bb_capture_bank.sv
// Multi-channel black-box harness: constant tie-offs, per-channel change
// counting and a valid/ready readout of {channel, last sample, count} records.
module bb_capture_bank
    import bb_capture_pkg::*;
#(
    parameter int             NUM_CH = 2,
    parameter int             OUT_W  = 2,
    parameter int             C_W    = 3,
    parameter logic           A_VAL  = 1'b0,
    parameter logic           B_VAL  = 1'b1,
    parameter logic [C_W-1:0] C_VAL  = 3'b010,
    parameter int             CNT_W  = CNT_W_DEF,
    parameter int             IDX_W  = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH*OUT_W-1:0] ch_out,
    input  logic [NUM_CH-1:0]       ch_cout,
    output logic [NUM_CH-1:0]       tie_a,
    output logic [NUM_CH-1:0]       tie_b,
    output logic [NUM_CH*C_W-1:0]   tie_c,
    input  logic                    rd_start,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [IDX_W-1:0]        rd_ch,
    output logic [OUT_W:0]          rd_sample,
    output logic [CNT_W-1:0]        rd_count,
    output logic                    rd_done,
    output logic                    busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    assign tie_a = {NUM_CH{A_VAL}};
    assign tie_b = {NUM_CH{B_VAL}};
    assign tie_c = {NUM_CH{C_VAL}};

    logic [NUM_CH-1:0][OUT_W:0]   samples;
    logic [NUM_CH-1:0][CNT_W-1:0] counts;
    logic [NUM_CH-1:0]            clr;
    logic [NUM_CH-1:0]            mismatch;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] load_idx;
    logic             load;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        assign clr[k] = (state_q == PRESENT) && rd_ready && (idx_q == IDX_W'(k));

        bb_capture_chan #(
            .OUT_W (OUT_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .din      ({ch_cout[k], ch_out[k*OUT_W +: OUT_W]}),
            .clr      (clr[k]),
            .sample   (samples[k]),
            .count    (counts[k]),
            .mismatch (mismatch[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        load     = 1'b0;
        load_idx = '0;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d = PRESENT;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            PRESENT: begin
                if (rd_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        load     = 1'b1;
                        load_idx = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Records are snapshots; later counter activity leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ch     <= '0;
            rd_sample <= '0;
            rd_count  <= '0;
        end else if (load) begin
            rd_ch     <= load_idx;
            rd_sample <= samples[load_idx];
            rd_count  <= counts[load_idx];
        end
    end

    assign rd_valid = (state_q == PRESENT);
    assign rd_done  = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule
